// File: rtl/q_ram_loader.sv
// Write sequencer for the complex matrix RAM: streams M1 then M2 row-major into four banks, one cycle accept-to-strobe.
// Backpressure: in_ready is high only while a load is active, so the source simply stalls outside a load.
`ifndef WORD_LEN
`define WORD_LEN 16
`endif
`ifndef MATRIX_DIM
`define MATRIX_DIM 4
`endif
`ifndef ADDR_BITS
`define ADDR_BITS 4
`endif

module q_ram_loader #(
  parameter int WORD_LEN   = `WORD_LEN,
  parameter int MATRIX_DIM = `MATRIX_DIM,
  parameter int ADDR_BITS  = `ADDR_BITS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WORD_LEN-1:0]  in_real,
  input  logic [WORD_LEN-1:0]  in_imag,
  input  logic                 in_last,
  output logic [3:0]           we,
  output logic [ADDR_BITS-1:0] Dir_M1,
  output logic [ADDR_BITS-1:0] Dir_M2,
  output logic [WORD_LEN-1:0]  data_m1_real,
  output logic [WORD_LEN-1:0]  data_m1_imag,
  output logic [WORD_LEN-1:0]  data_m2_real,
  output logic [WORD_LEN-1:0]  data_m2_imag,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  localparam int ELEMS = MATRIX_DIM * MATRIX_DIM;
  localparam logic [ADDR_BITS-1:0] LAST_IDX = ADDR_BITS'(ELEMS - 1);
  localparam logic [3:0] WE_M1 = 4'b0101;
  localparam logic [3:0] WE_M2 = 4'b1010;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD_M1 = 2'd1,
    LOAD_M2 = 2'd2
  } state_t;

  state_t               state, state_nxt;
  logic [ADDR_BITS-1:0] cnt, cnt_nxt;
  logic                 ready_nxt, busy_nxt, done_nxt, err_nxt;
  logic [3:0]           we_nxt;
  logic [ADDR_BITS-1:0] dir_m1_nxt, dir_m2_nxt;
  logic [WORD_LEN-1:0]  m1_real_nxt, m1_imag_nxt, m2_real_nxt, m2_imag_nxt;
  logic                 accept;
  logic                 last_elem;
  logic                 finish;

  assign accept    = in_valid && in_ready;
  assign last_elem = (cnt == LAST_IDX);

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    ready_nxt   = in_ready;
    busy_nxt    = busy;
    done_nxt    = 1'b0;
    err_nxt     = err;
    we_nxt      = 4'b0000;
    dir_m1_nxt  = Dir_M1;
    dir_m2_nxt  = Dir_M2;
    m1_real_nxt = data_m1_real;
    m1_imag_nxt = data_m1_imag;
    m2_real_nxt = data_m2_real;
    m2_imag_nxt = data_m2_imag;
    finish      = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = LOAD_M1;
          cnt_nxt   = '0;
          err_nxt   = 1'b0;
          ready_nxt = 1'b1;
          busy_nxt  = 1'b1;
        end
      end
      LOAD_M1: begin
        if (accept) begin
          we_nxt      = WE_M1;
          dir_m1_nxt  = cnt;
          m1_real_nxt = in_real;
          m1_imag_nxt = in_imag;
          // Any in_last inside M1 is premature: abort the load after this write.
          if (in_last) begin
            err_nxt = 1'b1;
            finish  = 1'b1;
          end else if (last_elem) begin
            cnt_nxt   = '0;
            state_nxt = LOAD_M2;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
      end
      LOAD_M2: begin
        if (accept) begin
          we_nxt      = WE_M2;
          dir_m2_nxt  = cnt;
          m2_real_nxt = in_real;
          m2_imag_nxt = in_imag;
          if (in_last || last_elem) begin
            // Framing is good only when in_last coincides with the final element.
            if (in_last != last_elem) begin
              err_nxt = 1'b1;
            end
            finish = 1'b1;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        ready_nxt = 1'b0;
        busy_nxt  = 1'b0;
      end
    endcase

    if (finish) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
      done_nxt  = 1'b1;
      ready_nxt = 1'b0;
      busy_nxt  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      in_ready     <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      we           <= 4'b0000;
      Dir_M1       <= '0;
      Dir_M2       <= '0;
      data_m1_real <= '0;
      data_m1_imag <= '0;
      data_m2_real <= '0;
      data_m2_imag <= '0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      in_ready     <= ready_nxt;
      busy         <= busy_nxt;
      done         <= done_nxt;
      err          <= err_nxt;
      we           <= we_nxt;
      Dir_M1       <= dir_m1_nxt;
      Dir_M2       <= dir_m2_nxt;
      data_m1_real <= m1_real_nxt;
      data_m1_imag <= m1_imag_nxt;
      data_m2_real <= m2_real_nxt;
      data_m2_imag <= m2_imag_nxt;
    end
  end

endmodule

// File: tb/tb_q_ram_loader.sv
// Directed bench for q_ram_loader with a 2x2 matrix (four elements per bank).
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_q_ram_loader;

  localparam int W = 16;
  localparam int A = 4;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_real;
  logic [W-1:0] in_imag;
  logic         in_last;
  logic [3:0]   we;
  logic [A-1:0] Dir_M1;
  logic [A-1:0] Dir_M2;
  logic [W-1:0] data_m1_real;
  logic [W-1:0] data_m1_imag;
  logic [W-1:0] data_m2_real;
  logic [W-1:0] data_m2_imag;
  logic         busy;
  logic         done;
  logic         err;

  int n_cmp  = 0;
  int n_fail = 0;

  q_ram_loader #(.WORD_LEN(W), .MATRIX_DIM(2), .ADDR_BITS(A)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_real(in_real), .in_imag(in_imag), .in_last(in_last),
    .we(we), .Dir_M1(Dir_M1), .Dir_M2(Dir_M2),
    .data_m1_real(data_m1_real), .data_m1_imag(data_m1_imag),
    .data_m2_real(data_m2_real), .data_m2_imag(data_m2_imag),
    .busy(busy), .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    #12;
    n_cmp++;
    if ({we, Dir_M1, Dir_M2, in_ready, busy, done, err} !== 15'd0) begin
      n_fail++;
      $display("FAIL reset_por: outputs=%h expected 0", {we, Dir_M1, Dir_M2, in_ready, busy, done, err});
    end
    rst_n = 1'b1;
    step();
    do_start();
    for (int k = 0; k < 2; k++) begin
      in_valid = 1'b1; in_real = 16'(500 + k); in_imag = 16'(600 + k); in_last = 1'b0;
      step();
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({we, Dir_M1, Dir_M2, in_ready, busy, done, err} !== 15'd0) begin
      n_fail++;
      $display("FAIL reset_async: outputs=%h expected 0", {we, Dir_M1, Dir_M2, in_ready, busy, done, err});
    end
    n_cmp++;
    if ({data_m1_real, data_m1_imag} !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_data: data_m1=%h expected 0", {data_m1_real, data_m1_imag});
    end
    rst_n = 1'b1;
    step();
    n_cmp++;
    if ({in_ready, busy, we} !== 6'd0) begin
      n_fail++;
      $display("FAIL reset_idle: ready/busy/we=%b expected 0", {in_ready, busy, we});
    end
    in_valid = 1'b0;
  endtask

  task automatic test_full_load();
    do_start();
    n_cmp++;
    if ({in_ready, busy} !== 2'b11) begin
      n_fail++;
      $display("FAIL full_start: ready/busy=%b expected 11", {in_ready, busy});
    end
    for (int k = 0; k < 8; k++) begin
      in_valid = 1'b1; in_real = 16'(k); in_imag = 16'(100 + k); in_last = (k == 7);
      step();
      if (k < 4) begin
        n_cmp++;
        if ({we, Dir_M1, data_m1_real, data_m1_imag} !== {4'b0101, 4'(k), 16'(k), 16'(100 + k)}) begin
          n_fail++;
          $display("FAIL full_m1 k=%0d: we=%b addr=%0d data=%0d/%0d expected 0101 %0d %0d/%0d",
                   k, we, Dir_M1, data_m1_real, data_m1_imag, k, k, 100 + k);
        end
      end else begin
        n_cmp++;
        if ({we, Dir_M2, data_m2_real, data_m2_imag} !== {4'b1010, 4'(k - 4), 16'(k), 16'(100 + k)}) begin
          n_fail++;
          $display("FAIL full_m2 k=%0d: we=%b addr=%0d data=%0d/%0d expected 1010 %0d %0d/%0d",
                   k, we, Dir_M2, data_m2_real, data_m2_imag, k - 4, k, 100 + k);
        end
        n_cmp++;
        if ({Dir_M1, data_m1_real, data_m1_imag} !== {4'd3, 16'd3, 16'd103}) begin
          n_fail++;
          $display("FAIL full_m1_hold k=%0d: addr=%0d data=%0d/%0d expected 3 3/103",
                   k, Dir_M1, data_m1_real, data_m1_imag);
        end
      end
      n_cmp++;
      if ({done, busy, in_ready, err} !== ((k == 7) ? 4'b1000 : 4'b0110)) begin
        n_fail++;
        $display("FAIL full_status k=%0d: done/busy/ready/err=%b expected %b",
                 k, {done, busy, in_ready, err}, (k == 7) ? 4'b1000 : 4'b0110);
      end
    end
    in_valid = 1'b0; in_last = 1'b0;
    step();
    n_cmp++;
    if ({we, done, busy} !== 6'd0) begin
      n_fail++;
      $display("FAIL full_after: we/done/busy=%b expected 0", {we, done, busy});
    end
  endtask

  task automatic test_bubbles();
    logic pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    int a = 0;
    int last_i = 0;
    do_start();
    for (int i = 0; i < 6; i++) begin
      in_valid = pat[i]; in_real = 16'(200 + i); in_imag = 16'(300 + i); in_last = 1'b0;
      step();
      if (pat[i]) begin
        n_cmp++;
        if ({we, Dir_M1, data_m1_real} !== {4'b0101, 4'(a), 16'(200 + i)}) begin
          n_fail++;
          $display("FAIL bubble_wr i=%0d: we=%b addr=%0d data=%0d expected 0101 %0d %0d",
                   i, we, Dir_M1, data_m1_real, a, 200 + i);
        end
        a++;
        last_i = i;
      end else begin
        n_cmp++;
        if ({we, Dir_M1, data_m1_real} !== {4'b0000, 4'(a - 1), 16'(200 + last_i)}) begin
          n_fail++;
          $display("FAIL bubble_idle i=%0d: we=%b addr=%0d data=%0d expected 0000 %0d %0d",
                   i, we, Dir_M1, data_m1_real, a - 1, 200 + last_i);
        end
      end
    end
    in_valid = 1'b0;
    do_reset();
  endtask

  task automatic test_early_last();
    do_start();
    for (int k = 0; k < 6; k++) begin
      in_valid = 1'b1; in_real = 16'(20 + k); in_imag = 16'(40 + k); in_last = (k == 5);
      step();
      if (k < 4) begin
        n_cmp++;
        if ({we, Dir_M1, data_m1_real} !== {4'b0101, 4'(k), 16'(20 + k)}) begin
          n_fail++;
          $display("FAIL early_m1 k=%0d: we=%b addr=%0d data=%0d expected 0101 %0d %0d",
                   k, we, Dir_M1, data_m1_real, k, 20 + k);
        end
      end else begin
        n_cmp++;
        if ({we, Dir_M2, data_m2_real} !== {4'b1010, 4'(k - 4), 16'(20 + k)}) begin
          n_fail++;
          $display("FAIL early_m2 k=%0d: we=%b addr=%0d data=%0d expected 1010 %0d %0d",
                   k, we, Dir_M2, data_m2_real, k - 4, 20 + k);
        end
      end
      n_cmp++;
      if ({done, busy, in_ready, err} !== ((k == 5) ? 4'b1001 : 4'b0110)) begin
        n_fail++;
        $display("FAIL early_status k=%0d: done/busy/ready/err=%b expected %b",
                 k, {done, busy, in_ready, err}, (k == 5) ? 4'b1001 : 4'b0110);
      end
    end
    in_valid = 1'b1; in_last = 1'b0; in_real = 16'd99;
    step();
    n_cmp++;
    if ({we, Dir_M2, done, err, busy, in_ready} !== {4'b0000, 4'd1, 1'b0, 1'b1, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL early_after: we=%b addr=%0d done/err/busy/ready=%b expected 0000 1 0100",
               we, Dir_M2, {done, err, busy, in_ready});
    end
    in_valid = 1'b0;
    do_start();
    n_cmp++;
    if ({err, busy, in_ready} !== 3'b011) begin
      n_fail++;
      $display("FAIL early_restart: err/busy/ready=%b expected 011", {err, busy, in_ready});
    end
    do_reset();
  endtask

  task automatic test_missing_last();
    int writes = 0;
    do_start();
    for (int k = 0; k < 8; k++) begin
      in_valid = 1'b1; in_real = 16'(k); in_imag = 16'(k); in_last = 1'b0;
      step();
      if (we !== 4'b0000) writes++;
    end
    n_cmp++;
    if ({done, err, we, Dir_M2} !== {1'b1, 1'b1, 4'b1010, 4'd3}) begin
      n_fail++;
      $display("FAIL missing_final: done/err=%b we=%b addr=%0d expected 11 1010 3",
               {done, err}, we, Dir_M2);
    end
    n_cmp++;
    if (writes !== 8) begin
      n_fail++;
      $display("FAIL missing_writes: got %0d expected 8", writes);
    end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_start_ignored_and_reset();
    do_start();
    n_cmp++;
    if ({err, busy} !== 2'b01) begin
      n_fail++;
      $display("FAIL ign_start: err/busy=%b expected 01", {err, busy});
    end
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1; in_real = 16'(50 + k); in_imag = 16'(60 + k); in_last = 1'b0;
      start = (k == 2);
      step();
      n_cmp++;
      if ({we, Dir_M1, data_m1_real, busy, err} !== {4'b0101, 4'(k), 16'(50 + k), 1'b1, 1'b0}) begin
        n_fail++;
        $display("FAIL ign_wr k=%0d: we=%b addr=%0d data=%0d busy/err=%b expected 0101 %0d %0d 10",
                 k, we, Dir_M1, data_m1_real, {busy, err}, k, 50 + k);
      end
    end
    start = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({we, Dir_M1, busy, in_ready} !== 10'd0) begin
      n_fail++;
      $display("FAIL ign_reset: we=%b addr=%0d busy/ready=%b expected 0", we, Dir_M1, {busy, in_ready});
    end
    rst_n = 1'b1;
    in_valid = 1'b0;
    step();
    do_start();
    in_valid = 1'b1; in_real = 16'd77; in_imag = 16'd88;
    step();
    n_cmp++;
    if ({we, Dir_M1, data_m1_real, data_m1_imag} !== {4'b0101, 4'd0, 16'd77, 16'd88}) begin
      n_fail++;
      $display("FAIL ign_restart: we=%b addr=%0d data=%0d/%0d expected 0101 0 77/88",
               we, Dir_M1, data_m1_real, data_m1_imag);
    end
    in_valid = 1'b0;
    step();
    do_reset();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0;
    in_real = '0; in_imag = '0; in_last = 1'b0;
    test_reset();
    test_full_load();
    test_bubbles();
    test_early_last();
    test_missing_last();
    test_start_ignored_and_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
